serial_word_loader: RTL and testbench

- Upstream feeder for the pattern-counting core (counter / shift register / control / decimal descriptor top).
- Assembles a serial bitstream into nBits-wide words, buffers one completed word, and issues it to the core.
- Issue handshake: drives in_data and pulses start, then tracks the core's ready through one full processing run before issuing the next word.
- Decouples bit arrival from core latency, with a sticky overrun flag when words arrive faster than the core consumes them.

---
 rtl/serial_word_loader_pkg.sv | 13 +
 rtl/serial_shift_in.sv | 37 +++
 rtl/serial_word_loader.sv | 89 ++++++++
 tb/tb_serial_word_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_loader_pkg.sv
// serial_word_loader_pkg: issue FSM state encoding and WAIT_LOW timeout shared by the loader
package serial_word_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOW  = 2'd1,
        S_WAIT_HIGH = 2'd2
    } state_t;

    // cycles spent in S_WAIT_LOW with core_ready still high before assuming an instant core
    localparam int WAIT_LOW_TIMEOUT = 2;

endpackage

// File: rtl/serial_shift_in.sv
// serial_shift_in: serial-to-parallel shift register with bit counter and word_done pulse
//   clock, reset      : rising-edge clock, async active-high reset
//   ser_bit, ser_valid: serial bit, sampled on edges where ser_valid=1
//   word              : completed word including the current ser_bit (valid with word_done)
//   word_done         : high in the cycle the nBits-th bit is presented
//   bit_cnt           : bits collected in the current partial word
module serial_shift_in #(
    parameter int  nBits    = 8,
    parameter bit  msbFirst = 1'b1,
    localparam int CW       = $clog2(nBits + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_bit,
    input  logic             ser_valid,
    output logic [nBits-1:0] word,
    output logic             word_done,
    output logic [CW-1:0]    bit_cnt
);

    logic [nBits-1:0] sr;

    // word is the shift register after this bit, so the completing bit is part of it
    assign word      = msbFirst ? {sr[nBits-2:0], ser_bit} : {ser_bit, sr[nBits-1:1]};
    assign word_done = ser_valid && (bit_cnt == CW'(nBits - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (ser_valid) begin
            sr      <= word;
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles serial bits into words, buffers one, and issues it to the counting core
//   clock, reset      : rising-edge clock, async active-high reset
//   ser_bit, ser_valid: serial input bit and its qualifier
//   core_ready        : core status, 1 = idle/done, 0 = processing
//   in_data, start    : word to the core and its one-cycle request pulse
//   word_pending      : holding register has a word not yet issued
//   overrun           : sticky, a completed word was dropped because the holding register was full
//   bit_cnt           : bits collected in the current partial word
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int  nBits    = 8,
    parameter bit  msbFirst = 1'b1,
    localparam int CW       = $clog2(nBits + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_bit,
    input  logic             ser_valid,
    input  logic             core_ready,
    output logic [nBits-1:0] in_data,
    output logic             start,
    output logic             word_pending,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    state_t           state, state_n;
    logic [nBits-1:0] hold, word;
    logic             word_done, issue, accept;
    logic [1:0]       wait_cnt;

    serial_shift_in #(.nBits(nBits), .msbFirst(msbFirst)) u_shift (
        .clock    (clock),
        .reset    (reset),
        .ser_bit  (ser_bit),
        .ser_valid(ser_valid),
        .word     (word),
        .word_done(word_done),
        .bit_cnt  (bit_cnt)
    );

    // a word finishing on the issue edge can reuse the slot being vacated
    assign accept = word_done && (!word_pending || issue);

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (word_pending && core_ready) begin
                    issue   = 1'b1;
                    state_n = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW:
                state_n = !core_ready ? S_WAIT_HIGH :
                          (wait_cnt == 2'(WAIT_LOW_TIMEOUT - 1)) ? S_IDLE : S_WAIT_LOW;
            S_WAIT_HIGH:
                state_n = core_ready ? S_IDLE : S_WAIT_HIGH;
            default:
                state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 2'd0;
            hold         <= '0;
            in_data      <= '0;
            start        <= 1'b0;
            word_pending <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_n;
            wait_cnt     <= (state == S_WAIT_LOW) ? wait_cnt + 2'd1 : 2'd0;
            start        <= issue;
            word_pending <= accept | (word_pending & ~issue);
            if (issue)
                in_data <= hold;
            if (accept)
                hold <= word;
            if (word_done && !accept)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: self-checking bench for serial_word_loader, MSB-first and LSB-first instances
module tb_serial_word_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ser_bit = 1'b0;
    logic       ser_valid = 1'b0;
    logic       core_ready = 1'b1;
    logic [7:0] in_data_m, in_data_l;
    logic       start_m, start_l, pend_m, pend_l, ovr_m, ovr_l;
    logic [3:0] cnt_m, cnt_l;

    int         tests = 0;
    int         fails = 0;
    bit         auto_core = 1'b0;
    int         busy_len = 5;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    typedef struct {
        logic [7:0] seq;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;
    vec_t vt[5];

    always #5 clock = ~clock;

    serial_word_loader #(.nBits(8), .msbFirst(1'b1)) dut_m (
        .clock(clock), .reset(reset), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .core_ready(core_ready), .in_data(in_data_m), .start(start_m),
        .word_pending(pend_m), .overrun(ovr_m), .bit_cnt(cnt_m)
    );

    serial_word_loader #(.nBits(8), .msbFirst(1'b0)) dut_l (
        .clock(clock), .reset(reset), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .core_ready(core_ready), .in_data(in_data_l), .start(start_l),
        .word_pending(pend_l), .overrun(ovr_l), .bit_cnt(cnt_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every start must carry the oldest expected word
    always @(negedge clock) begin
        if (start_m) begin
            if (q_m.size() == 0) check("start msb with empty queue", start_m, 0);
            else check("in_data msb", in_data_m, q_m.pop_front());
        end
        if (start_l) begin
            if (q_l.size() == 0) check("start lsb with empty queue", start_l, 0);
            else check("in_data lsb", in_data_l, q_l.pop_front());
        end
    end

    // core model: drop ready the edge after start is seen, stay busy busy_len cycles
    initial forever begin
        @(negedge clock);
        if (auto_core && start_m) begin
            @(posedge clock); #1 core_ready = 1'b0;
            repeat (busy_len) @(posedge clock);
            #1 core_ready = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input vec_t v);
        q_m.push_back(v.exp_m);
        q_l.push_back(v.exp_l);
    endtask

    task automatic send_bits(input logic [7:0] seq, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            ser_bit   = seq[i];
            ser_valid = 1'b1;
            @(posedge clock); #1;
        end
        ser_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!start_m && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check({name, " start seen"}, start_m, 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q_m.size() != 0 || pend_m) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check({name, " drained"}, q_m.size(), 0);
        repeat (busy_len + 8) @(posedge clock);
        #1;
    endtask

    initial begin
        vt[0] = '{8'b1011_0010, 8'hB2, 8'h4D};
        vt[1] = '{8'hFF, 8'hFF, 8'hFF};
        vt[2] = '{8'h01, 8'h01, 8'h80};
        vt[3] = '{8'hC5, 8'hC5, 8'hA3};
        vt[4] = '{8'h96, 8'h96, 8'h69};

        // reset values
        #2;
        check("reset in_data msb", in_data_m, 0);
        check("reset in_data lsb", in_data_l, 0);
        check("reset start", start_m, 0);
        check("reset pending", pend_m, 0);
        check("reset overrun", ovr_m, 0);
        check("reset bit_cnt", cnt_m, 0);
        @(posedge clock); #1 reset = 1'b0;

        // reset mid-word clears the partial word at once
        send_bits(8'hFF, 3);
        check("partial bit_cnt", cnt_m, 3);
        #2 reset = 1'b1;
        #1;
        check("async reset bit_cnt", cnt_m, 0);
        check("async reset bit_cnt lsb", cnt_l, 0);
        @(posedge clock); #1 reset = 1'b0;

        // table: single words through an idle core
        auto_core = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(vt[k]);
            send_bits(vt[k].seq, 8);
            check($sformatf("vec%0d pending", k), pend_m, 1);
            check($sformatf("vec%0d no early start", k), start_m, 0);
            check($sformatf("vec%0d bit_cnt", k), cnt_m, 0);
            @(posedge clock); #1;
            check($sformatf("vec%0d start", k), start_m, 1);
            check($sformatf("vec%0d pending cleared", k), pend_m, 0);
            wait_drain($sformatf("vec%0d", k));
        end
        auto_core = 1'b0;

        // busy core holds the word until ready returns
        begin
            int starts = 0;
            core_ready = 1'b0;
            push(vt[0]);
            send_bits(vt[0].seq, 8);
            repeat (32) begin
                @(posedge clock); #1;
                if (start_m) starts++;
            end
            check("busy no start", starts, 0);
            check("busy pending", pend_m, 1);
            core_ready = 1'b1;
            @(posedge clock); #1;
            check("busy start after ready", start_m, 1);
            wait_drain("busy");
        end

        // overrun: second word dropped while the first is held
        core_ready = 1'b0;
        push(vt[3]);
        send_bits(vt[3].seq, 8);
        send_bits(vt[4].seq, 8);
        check("overrun msb", ovr_m, 1);
        check("overrun lsb", ovr_l, 1);
        check("overrun pending", pend_m, 1);
        core_ready = 1'b1;
        wait_start("overrun");
        wait_drain("overrun");
        check("overrun sticky", ovr_m, 1);
        reset = 1'b1;
        #1;
        check("overrun cleared by reset", ovr_m, 0);
        @(posedge clock); #1 reset = 1'b0;

        // back-to-back: word 2 completes on the edge that issues word 1
        core_ready = 1'b0;
        push(vt[1]);
        push(vt[2]);
        send_bits(vt[1].seq, 8);
        send_bits(vt[2].seq, 7);
        ser_bit    = vt[2].seq[0];
        ser_valid  = 1'b1;
        core_ready = 1'b1;
        @(posedge clock); #1;
        ser_valid = 1'b0;
        check("b2b start", start_m, 1);
        check("b2b pending kept", pend_m, 1);
        check("b2b no overrun", ovr_m, 0);
        @(posedge clock); #1 core_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 core_ready = 1'b1;
        wait_start("b2b word2");
        check("b2b pending after word2", pend_m, 0);
        wait_drain("b2b");
        check("b2b overrun still clear", ovr_m, 0);

        check("msb queue empty", q_m.size(), 0);
        check("lsb queue empty", q_l.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
